// File: rtl/pipe_hazard_ctrl_pkg.sv
// ============================================================================
// pipe_hazard_ctrl_pkg : opcodes, FSM states and forward-select encodings
// Rev 1.0
// ============================================================================
`default_nettype none

package pipe_hazard_ctrl_pkg;

  localparam int REG_W = 4;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_LOAD = 2'b10,
    OP_NOP  = 2'b11
  } opcode_e;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_LOAD   = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_HALTED = 3'd3,
    ST_ERR    = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_EX = 2'b01,
    FWD_WB = 2'b10
  } fwd_e;

  function automatic logic op_writes(input logic [1:0] op);
    return op != OP_NOP;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
// ============================================================================
// pipe_hazard_ctrl_if : ID-stage / data-memory / enable bundle of the controller
// Rev 1.0
// ============================================================================
`default_nettype none

interface pipe_hazard_ctrl_if
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNTW = 16
);
  logic             id_valid;
  logic [1:0]       id_opcode;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic [REG_W-1:0] id_rd;
  logic             halt_req;
  logic             dmem_ack;
  logic             pc_en;
  logic             if_id_en;
  logic             id_ex_en;
  logic             id_ex_bubble;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             dmem_req;
  logic             load_done;
  logic             load_err;
  logic             halted;
  logic [CNTW-1:0]  stall_cnt;

  modport master (
    output id_valid, id_opcode, id_rs1, id_rs2, id_rd, halt_req, dmem_ack,
    input  pc_en, if_id_en, id_ex_en, id_ex_bubble, fwd_a, fwd_b,
    input  dmem_req, load_done, load_err, halted, stall_cnt
  );

  modport slave (
    input  id_valid, id_opcode, id_rs1, id_rs2, id_rd, halt_req, dmem_ack,
    output pc_en, if_id_en, id_ex_en, id_ex_bubble, fwd_a, fwd_b,
    output dmem_req, load_done, load_err, halted, stall_cnt
  );
endinterface

`default_nettype wire

// File: rtl/hazard_fwd_sel.sv
// ============================================================================
// hazard_fwd_sel : operand bypass select for one source register, EX over WB
// Rev 1.0
// ============================================================================
`default_nettype none

module hazard_fwd_sel
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] rs,
  input  logic             ex_v,
  input  logic             ex_wr,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             wb_v,
  input  logic             wb_wr,
  input  logic [REG_W-1:0] wb_rd,
  output logic [1:0]       fwd
);
  always_comb begin
    fwd = FWD_RF;
    if (ex_v && ex_wr && (ex_rd == rs)) begin
      fwd = FWD_EX;
    end else if (wb_v && wb_wr && (wb_rd == rs)) begin
      fwd = FWD_WB;
    end
  end
endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// pipe_hazard_ctrl : stall, forwarding, load-wait and drain/halt control
// Rev 1.0
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNTW    = 16
) (
  input  logic              clk,
  input  logic              reset,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int WAIT_W = $clog2(TIMEOUT) + 1;

  state_e           state_q, state_d;
  logic             ret_drain_q, ret_drain_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic             load_err_q, load_err_d;
  logic [CNTW-1:0]  stall_q, stall_d;
  logic             ex_v_q, ex_v_d, ex_wr_q, ex_wr_d, ex_ld_q, ex_ld_d;
  logic [REG_W-1:0] ex_rd_q, ex_rd_d, wb_rd_q, wb_rd_d;
  logic             wb_v_q, wb_v_d, wb_wr_q, wb_wr_d;

  logic advance, load_ack, ack_to_drain, shift, draining, ex_take;

  always_comb begin
    advance      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    load_ack     = (state_q == ST_LOAD) && bus.dmem_ack;
    ack_to_drain = ret_drain_q || bus.halt_req;
    // A completing load moves the shadow pipe even though the enables stay low.
    shift        = advance || load_ack;
    draining     = (state_q == ST_DRAIN) || (load_ack && ack_to_drain);
    ex_take      = bus.id_valid && !draining && (bus.id_opcode != OP_NOP);
  end

  always_comb begin
    ex_v_d  = ex_v_q;
    ex_wr_d = ex_wr_q;
    ex_ld_d = ex_ld_q;
    ex_rd_d = ex_rd_q;
    wb_v_d  = wb_v_q;
    wb_wr_d = wb_wr_q;
    wb_rd_d = wb_rd_q;
    if (shift) begin
      ex_v_d  = ex_take;
      ex_wr_d = op_writes(bus.id_opcode);
      ex_ld_d = (bus.id_opcode == OP_LOAD);
      ex_rd_d = bus.id_rd;
      wb_v_d  = ex_v_q;
      wb_wr_d = ex_wr_q;
      wb_rd_d = ex_rd_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    ret_drain_d = ret_drain_q;
    wait_d      = wait_q;
    load_err_d  = load_err_q;
    stall_d     = stall_q;
    case (state_q)
      ST_RUN: begin
        if (ex_v_q && ex_ld_q) begin
          state_d     = ST_LOAD;
          ret_drain_d = 1'b0;
          wait_d      = '0;
        end else if (bus.halt_req) begin
          state_d = ST_DRAIN;
        end
      end
      ST_LOAD: begin
        if (bus.dmem_ack) begin
          state_d = ack_to_drain ? ST_DRAIN : ST_RUN;
        end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
          state_d    = ST_ERR;
          load_err_d = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_DRAIN: begin
        if (ex_v_q && ex_ld_q) begin
          state_d     = ST_LOAD;
          ret_drain_d = 1'b1;
          wait_d      = '0;
        end else if (!bus.halt_req) begin
          state_d = ST_RUN;
        end else if (!ex_v_d && !wb_v_d) begin
          state_d = ST_HALTED;
        end
      end
      ST_HALTED: begin
        if (!bus.halt_req) state_d = ST_RUN;
      end
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_RUN;
    endcase
    if (!advance && (stall_q != {CNTW{1'b1}})) begin
      stall_d = stall_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      ret_drain_q <= 1'b0;
      wait_q      <= '0;
      load_err_q  <= 1'b0;
      stall_q     <= '0;
      ex_v_q      <= 1'b0;
      ex_wr_q     <= 1'b0;
      ex_ld_q     <= 1'b0;
      ex_rd_q     <= '0;
      wb_v_q      <= 1'b0;
      wb_wr_q     <= 1'b0;
      wb_rd_q     <= '0;
    end else begin
      state_q     <= state_d;
      ret_drain_q <= ret_drain_d;
      wait_q      <= wait_d;
      load_err_q  <= load_err_d;
      stall_q     <= stall_d;
      ex_v_q      <= ex_v_d;
      ex_wr_q     <= ex_wr_d;
      ex_ld_q     <= ex_ld_d;
      ex_rd_q     <= ex_rd_d;
      wb_v_q      <= wb_v_d;
      wb_wr_q     <= wb_wr_d;
      wb_rd_q     <= wb_rd_d;
    end
  end

  assign bus.pc_en        = (state_q == ST_RUN);
  assign bus.if_id_en     = (state_q == ST_RUN);
  assign bus.id_ex_en     = advance;
  assign bus.id_ex_bubble = advance && (!bus.id_valid || (state_q == ST_DRAIN));
  assign bus.dmem_req     = (state_q == ST_LOAD);
  assign bus.load_done    = load_ack;
  assign bus.load_err     = load_err_q;
  assign bus.halted       = (state_q == ST_HALTED);
  assign bus.stall_cnt    = stall_q;

  hazard_fwd_sel u_fwd_a (
    .rs    (bus.id_rs1),
    .ex_v  (ex_v_q),
    .ex_wr (ex_wr_q),
    .ex_rd (ex_rd_q),
    .wb_v  (wb_v_q),
    .wb_wr (wb_wr_q),
    .wb_rd (wb_rd_q),
    .fwd   (bus.fwd_a)
  );

  hazard_fwd_sel u_fwd_b (
    .rs    (bus.id_rs2),
    .ex_v  (ex_v_q),
    .ex_wr (ex_wr_q),
    .ex_rd (ex_rd_q),
    .wb_v  (wb_v_q),
    .wb_wr (wb_wr_q),
    .wb_rd (wb_rd_q),
    .fwd   (bus.fwd_b)
  );
endmodule

`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum cycles dmem_req is held waiting for dmem_ack.
REQ-002 Parameter CNTW, default 16: width of stall_cnt.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 id_valid  in  1  ID stage holds a real instruction.
REQ-006 id_opcode  in  2  ID opcode: 00 ADD, 01 SUB, 10 LOAD, 11 NOP.
REQ-007 id_rs1, id_rs2, id_rd  in  4 each  ID source and destination register indices.
REQ-008 halt_req  in  1  level request to drain and stop the pipeline.
REQ-009 dmem_ack  in  1  data memory accepts and completes the LOAD access.
REQ-010 pc_en, if_id_en, id_ex_en  out  1 each  enables for the PC, IF/ID and ID/EX registers.
REQ-011 id_ex_bubble  out  1  load a NOP into ID/EX instead of the ID contents.
REQ-012 fwd_a, fwd_b  out  2 each  operand source: 00 regfile, 01 EX result, 10 WB result.
REQ-013 dmem_req  out  1  LOAD access request.
REQ-014 load_done  out  1  one-cycle pulse on LOAD completion.
REQ-015 load_err  out  1  sticky LOAD timeout flag.
REQ-016 halted  out  1  pipeline drained and stopped.
REQ-017 stall_cnt  out  CNTW  saturating count of frozen cycles.

Function
REQ-018 FSM states: RUN, LOAD, DRAIN, HALTED, ERR.
REQ-019 Shadow pipeline: ex_v/ex_rd/ex_wr/ex_ld and wb_v/wb_rd/wb_wr, mirroring ID/EX and EX/WB occupancy.
REQ-020 advance = 1 in RUN and DRAIN, 0 otherwise; pc_en = if_id_en = id_ex_en = advance, except pc_en = if_id_en = 0 in DRAIN.
REQ-021 On advance: ex_* loads ID fields if id_valid and not DRAIN and id_opcode != 11, else ex_v = 0; wb_* loads ex_*.
REQ-022 ex_wr = 1 for opcodes 00, 01, 10; wb_wr = ex_wr.
REQ-023 id_ex_bubble = advance AND (NOT id_valid OR DRAIN).
REQ-024 Without advance, all shadow registers hold.
REQ-025 fwd_a = 01 if ex_v & ex_wr & ex_rd == id_rs1; else 10 if wb_v & wb_wr & wb_rd == id_rs1; else 00. EX has priority over WB.
REQ-026 fwd_b uses the same rule with id_rs2.
REQ-027 RUN -> LOAD when ex_v & ex_ld. Evaluated before halt_req, so LOAD wins over simultaneous halt.
REQ-028 LOAD: dmem_req = 1 and the wait counter increments each cycle.
REQ-029 LOAD with dmem_ack -> RUN, load_done = 1 for that cycle, and the shadow pipeline advances on the same edge.
REQ-030 dmem_ack in the first LOAD cycle (zero wait) is legal.
REQ-031 LOAD with no dmem_ack when the counter reaches TIMEOUT-1 -> ERR, and load_err is set.
REQ-032 ERR: dmem_req = 0, all enables 0, and load_err stays 1 until reset.
REQ-033 RUN with halt_req and no LOAD transition -> DRAIN.
REQ-034 DRAIN -> HALTED when ex_v = 0 and wb_v = 0 after the current edge.
REQ-035 DRAIN reaching a LOAD in EX -> LOAD; after completion it returns to DRAIN, not RUN.
REQ-036 HALTED: halted = 1 and all enables 0; halt_req = 0 -> RUN on the next edge.
REQ-037 halt_req dropped during DRAIN -> RUN.
REQ-038 stall_cnt increments each cycle that advance = 0 and saturates at all-ones.
REQ-039 dmem_ack outside LOAD is ignored.

Reset
REQ-040 On reset: state = RUN, all shadow valids = 0, stall_cnt = 0, load_err = 0, dmem_req = 0, load_done = 0, halted = 0, fwd_a = fwd_b = 00.
REQ-041 Reset mid-LOAD drops dmem_req immediately (asynchronous).
REQ-042 Outputs are derived from state only, so pc_en = if_id_en = id_ex_en = 1 and id_ex_bubble = NOT id_valid in the reset state.

Structure
REQ-043 A shared package holds the opcode constants (ADD, SUB, LOAD, NOP), the state enum, and the fwd select encodings.
REQ-044 One sub-module, hazard_fwd_sel, is the combinational forwarding comparator and is instantiated once per operand.
REQ-045 All other logic is in pipe_hazard_ctrl.

Verification
REQ-046 ADD r3 = r1 + r2, then SUB r4 = r3 - r1 on the next cycle -> fwd_a = 01 for the SUB; a third instruction reading r3 two cycles later -> fwd_a = 10.
REQ-047 LOAD in EX with dmem_ack after 3 cycles -> dmem_req high 3 cycles, all enables 0 for 3 cycles, load_done pulse, stall_cnt = 3.
REQ-048 LOAD with no ack and TIMEOUT = 16 -> ERR after 16 cycles, load_err = 1, enables stay 0 until reset, then all outputs return to reset values.
REQ-049 halt_req with 2 instructions in flight -> pc_en = 0 at once, halted = 1 after 2 cycles; dropping halt_req -> RUN on the next edge.
REQ-050 halt_req asserted in the same cycle a LOAD enters EX -> LOAD first; after ack -> DRAIN, then HALTED.
REQ-051 stall_cnt preset near saturation with CNTW = 4 and 20 frozen cycles -> stall_cnt = 15, no wrap.
